// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared types, constants and helpers for the byte-serial
//                memory controller (FSM states, request owner, lane search).
//  Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    // Cycles from ram_addr_o presented to ram_din_i valid (fixed in this revision)
    localparam int          RAM_LAT   = 1;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        MC_IDLE   = 3'd0,
        MC_MREAD  = 3'd1,
        MC_MWRITE = 3'd2,
        MC_IREAD  = 3'd3,
        MC_DONE   = 3'd4
    } mc_state_e;

    typedef enum logic {
        OWN_MEM = 1'b0,
        OWN_IF  = 1'b1
    } owner_e;

    // Index of the lowest set bit of a 4-bit lane mask (0 when mask is empty)
    function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
        logic [1:0] lane;
        lane = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k]) begin
                lane = 2'(k);
            end
        end
        return lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Serialises MEM loads/stores and instruction fetches onto a
//                byte-wide external RAM. Reads assemble four bytes into a
//                little-endian word; stores write only the enabled lanes.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_done_o,

    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_done_o,

    output logic        stallreq_o,

    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    mc_state_e   state_q;
    owner_e      owner_q;
    logic [2:0]  cnt_q;      // read sequencing: address-issue edges seen so far
    logic [31:0] base_q;     // word-aligned base address of the request
    logic [31:0] wdata_q;    // latched store data
    logic [3:0]  pend_q;     // store lanes still to be written
    logic [23:0] rdata_q;    // bytes 0..2 of the word being read

    logic [31:0] mem_data_q;
    logic        mem_done_q;
    logic [31:0] if_data_q;
    logic        if_done_q;
    logic [31:0] ram_addr_q;
    logic        ram_wr_q;
    logic [7:0]  ram_dout_q;

    // ------------------------------------------------------------------
    // Next-value helpers
    // ------------------------------------------------------------------
    logic [31:0] base_d;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;
    logic [31:0] wbase_d;
    logic [1:0]  wlane_d;
    logic [7:0]  wbyte_d;
    logic [3:0]  wrest_d;
    logic [1:0]  rlane_d;
    logic [1:0]  roff_d;
    logic [31:0] rword_d;

    // Address bits [1:0] are dropped: the controller always moves whole words
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^{mem_addr_i[1:0], if_addr_i[1:0]};

    // Store lane selection: in IDLE look at the live request, afterwards at the latched copy
    always_comb begin
        base_d  = {(mem_ce_i ? mem_addr_i[31:2] : if_addr_i[31:2]), 2'b00};
        wmask_d = (state_q == MC_IDLE) ? mem_sel_i  : pend_q;
        wdata_d = (state_q == MC_IDLE) ? mem_data_i : wdata_q;
        wbase_d = (state_q == MC_IDLE) ? base_d     : base_q;
        wlane_d = lowest_lane(wmask_d);
        wbyte_d = wdata_d[{wlane_d, 3'b000} +: 8];
        wrest_d = wmask_d & ~(4'b0001 << wlane_d);
        // Byte arriving now was addressed RAM_LAT edges ago
        rlane_d = 2'(cnt_q - 3'(RAM_LAT));
        roff_d  = cnt_q[1:0] + 2'd1;
        rword_d = {ram_din_i, rdata_q};
    end

    // Main FSM with registered RAM-side and completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MC_IDLE;
            owner_q    <= OWN_MEM;
            cnt_q      <= 3'd0;
            base_q     <= ZERO_WORD;
            wdata_q    <= ZERO_WORD;
            pend_q     <= 4'd0;
            rdata_q    <= 24'd0;
            mem_data_q <= ZERO_WORD;
            mem_done_q <= 1'b0;
            if_data_q  <= ZERO_WORD;
            if_done_q  <= 1'b0;
            ram_addr_q <= ZERO_WORD;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= 8'd0;
        end else begin
            // RAM bus is quiet and done pulses drop unless a branch below drives them
            mem_done_q <= 1'b0;
            if_done_q  <= 1'b0;
            ram_addr_q <= ZERO_WORD;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= 8'd0;

            case (state_q)
                MC_IDLE: begin
                    if (mem_ce_i || if_ce_i) begin
                        base_q <= base_d;
                        cnt_q  <= 3'd0;
                    end
                    if (mem_ce_i) begin
                        owner_q <= OWN_MEM;
                        wdata_q <= mem_data_i;
                        if (mem_we_i) begin
                            if (mem_sel_i != 4'd0) begin
                                // First enabled lane goes out on the very next cycle
                                ram_addr_q <= {wbase_d[31:2], wlane_d};
                                ram_dout_q <= wbyte_d;
                                ram_wr_q   <= 1'b1;
                                pend_q     <= wrest_d;
                                state_q    <= MC_MWRITE;
                            end else begin
                                // Empty byte-enable store completes without touching RAM
                                mem_done_q <= 1'b1;
                                state_q    <= MC_DONE;
                            end
                        end else begin
                            ram_addr_q <= base_d;
                            state_q    <= MC_MREAD;
                        end
                    end else if (if_ce_i) begin
                        owner_q    <= OWN_IF;
                        ram_addr_q <= base_d;
                        state_q    <= MC_IREAD;
                    end
                end

                MC_MREAD, MC_IREAD: begin
                    // Bytes 0..2 are buffered; byte 3 goes straight into the result
                    if (cnt_q >= 3'(RAM_LAT)) begin
                        case (rlane_d)
                            2'd0:    rdata_q[7:0]   <= ram_din_i;
                            2'd1:    rdata_q[15:8]  <= ram_din_i;
                            2'd2:    rdata_q[23:16] <= ram_din_i;
                            default: ;
                        endcase
                    end
                    if (cnt_q == 3'(3 + RAM_LAT)) begin
                        state_q <= MC_DONE;
                        if (owner_q == OWN_MEM) begin
                            mem_done_q <= 1'b1;
                            mem_data_q <= rword_d;
                        end else begin
                            if_done_q <= 1'b1;
                            if_data_q <= rword_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q < 3'd3) begin
                            ram_addr_q <= {base_q[31:2], roff_d};
                        end
                    end
                end

                MC_MWRITE: begin
                    if (pend_q != 4'd0) begin
                        ram_addr_q <= {wbase_d[31:2], wlane_d};
                        ram_dout_q <= wbyte_d;
                        ram_wr_q   <= 1'b1;
                        pend_q     <= wrest_d;
                    end else begin
                        // Stores leave mem_data_o untouched; only loads produce a word
                        mem_done_q <= 1'b1;
                        state_q    <= MC_DONE;
                    end
                end

                MC_DONE: begin
                    state_q <= MC_IDLE;
                end

                default: begin
                    state_q <= MC_IDLE;
                end
            endcase
        end
    end

    assign mem_data_o = mem_data_q;
    assign mem_done_o = mem_done_q;
    assign if_data_o  = if_data_q;
    assign if_done_o  = if_done_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_wr_o   = ram_wr_q;
    assign ram_dout_o = ram_dout_q;

    // MEM must stall until its own transaction reports completion
    assign stallreq_o = mem_ce_i & ~mem_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Scoreboard bench for mem_ctrl with a byte-wide RAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i, mem_we_i;
    logic [31:0] mem_addr_i, mem_data_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_o;
    logic        mem_done_o;
    logic        if_ce_i;
    logic [31:0] if_addr_i, if_data_o;
    logic        if_done_o;
    logic        stallreq_o;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .mem_done_o (mem_done_o),
        .if_ce_i    (if_ce_i),
        .if_addr_i  (if_addr_i),
        .if_data_o  (if_data_o),
        .if_done_o  (if_done_o),
        .stallreq_o (stallreq_o),
        .ram_addr_o (ram_addr_o),
        .ram_wr_o   (ram_wr_o),
        .ram_dout_o (ram_dout_o),
        .ram_din_i  (ram_din_i)
    );

    // Cycle c is the interval following the c-th rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // RAM model: one-cycle read latency, write committed at the edge
    // ------------------------------------------------------------------
    logic [7:0] ram [0:4095];
    logic       ram_loaded = 1'b0;

    function automatic logic [7:0] preset(input int a);
        case (a)
            'h000: return 8'hDE;  'h001: return 8'hAD;  'h002: return 8'hBE;  'h003: return 8'hEF;
            'h004: return 8'h01;  'h005: return 8'h23;  'h006: return 8'h45;  'h007: return 8'h67;
            'h100: return 8'h11;  'h101: return 8'h22;  'h102: return 8'h33;  'h103: return 8'h44;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] <= preset(i);
            ram_loaded <= 1'b1;
        end else if (ram_wr_o) begin
            ram[ram_addr_o[11:0]] <= ram_dout_o;
        end
        ram_din_i <= ram[ram_addr_o[11:0]];
    end

    // ------------------------------------------------------------------
    // Scoreboard queues and monitor
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk_data;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    rsp_t exp_mem[$];
    rsp_t exp_if[$];
    wr_t  exp_wr[$];
    rsp_t mon_r;
    wr_t  mon_w;

    always @(negedge clk) begin
        if (mem_done_o) begin
            if (exp_mem.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL mem_done unexpected: got pulse expected none (cycle %0d)", cyc);
            end else begin
                mon_r = exp_mem.pop_front();
                chk("mem_done_cycle", 32'(cyc), 32'(mon_r.cyc));
                if (mon_r.chk_data) chk("mem_data", mem_data_o, mon_r.data);
            end
        end
        if (if_done_o) begin
            if (exp_if.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL if_done unexpected: got pulse expected none (cycle %0d)", cyc);
            end else begin
                mon_r = exp_if.pop_front();
                chk("if_done_cycle", 32'(cyc), 32'(mon_r.cyc));
                if (mon_r.chk_data) chk("if_data", if_data_o, mon_r.data);
            end
        end
        if (ram_wr_o) begin
            if (exp_wr.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL ram_wr unexpected: got write %h@%h expected none (cycle %0d)",
                         ram_dout_o, ram_addr_o, cyc);
            end else begin
                mon_w = exp_wr.pop_front();
                chk("wr_addr", ram_addr_o, mon_w.addr);
                chk("wr_data", {24'd0, ram_dout_o}, {24'd0, mon_w.data});
                chk("wr_cycle", 32'(cyc), 32'(mon_w.cyc));
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers: hold the request until done, optionally disturb the inputs
    // once the request is known to have been accepted
    // ------------------------------------------------------------------
    task automatic mem_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data, input bit scramble);
        int n;
        mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
        @(posedge clk); #1;
        if (scramble) begin
            mem_addr_i = ~addr; mem_sel_i = ~sel; mem_data_i = ~data;
        end
        n = 0;
        while (!mem_done_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mem_done_seen", {31'd0, mem_done_o}, 32'd1);
        @(posedge clk); #1;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0; mem_sel_i = 4'd0; mem_data_i = 32'd0;
    endtask

    task automatic if_req(input logic [31:0] addr, input bit scramble);
        int n;
        if_ce_i = 1'b1; if_addr_i = addr;
        @(posedge clk); #1;
        if (scramble) if_addr_i = ~addr;
        n = 0;
        while (!if_done_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("if_done_seen", {31'd0, if_done_o}, 32'd1);
        @(posedge clk); #1;
        if_ce_i = 1'b0; if_addr_i = 32'd0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ram_wr"},   {31'd0, ram_wr_o},   32'd0);
        chk({tag, "_ram_addr"}, ram_addr_o,          32'd0);
        chk({tag, "_ram_dout"}, {24'd0, ram_dout_o}, 32'd0);
        chk({tag, "_mem_done"}, {31'd0, mem_done_o}, 32'd0);
        chk({tag, "_if_done"},  {31'd0, if_done_o},  32'd0);
        chk({tag, "_mem_data"}, mem_data_o,          32'd0);
        chk({tag, "_if_data"},  if_data_o,           32'd0);
        chk({tag, "_stallreq"}, {31'd0, stallreq_o}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int c0;

    initial begin
        rst = 1'b1;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0; mem_sel_i = 4'd0; mem_data_i = 32'd0;
        if_ce_i = 1'b0; if_addr_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a full-word store, after bytes 0 and 1
        c0 = cyc;
        exp_wr.push_back('{addr: 32'h300, data: 8'h44, cyc: c0 + 1});
        exp_wr.push_back('{addr: 32'h301, data: 8'h33, cyc: c0 + 2});
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h300; mem_sel_i = 4'hF; mem_data_i = 32'h1122_3344;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'd0; mem_data_i = 32'd0; mem_addr_i = 32'd0;
        #1;
        chk_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ram300", {24'd0, ram[12'h300]}, 32'h44);
        chk("midrst_ram301", {24'd0, ram[12'h301]}, 32'h33);
        chk("midrst_ram302", {24'd0, ram[12'h302]}, 32'h58);
        chk("midrst_ram303", {24'd0, ram[12'h303]}, 32'h59);
        chk("midrst_idle_wr", {31'd0, ram_wr_o}, 32'd0);

        // Load word at 0x100 with address trace and stall window
        c0 = cyc;
        exp_mem.push_back('{data: 32'h4433_2211, cyc: c0 + 6, chk_data: 1'b1});
        fork
            mem_req(1'b0, 32'h100, 4'hF, 32'd0, 1'b1);
            begin
                for (int k = 0; k <= 6; k++) begin
                    @(negedge clk);
                    chk("load_stallreq", {31'd0, stallreq_o}, (k <= 5) ? 32'd1 : 32'd0);
                    if (k >= 1 && k <= 4) begin
                        chk("load_ram_addr", ram_addr_o, 32'h100 + 32'(k - 1));
                        chk("load_ram_wr", {31'd0, ram_wr_o}, 32'd0);
                    end
                end
            end
        join

        // Store byte to lane 3
        c0 = cyc;
        exp_wr.push_back('{addr: 32'h203, data: 8'hA5, cyc: c0 + 1});
        exp_mem.push_back('{data: 32'd0, cyc: c0 + 2, chk_data: 1'b0});
        mem_req(1'b1, 32'h203, 4'b1000, 32'hA5A5_A5A5, 1'b1);
        chk("sb_ram200", {24'd0, ram[12'h200]}, 32'h5A);
        chk("sb_ram201", {24'd0, ram[12'h201]}, 32'h5B);
        chk("sb_ram202", {24'd0, ram[12'h202]}, 32'h58);
        chk("sb_ram203", {24'd0, ram[12'h203]}, 32'hA5);

        // Store half to lanes 2/3
        c0 = cyc;
        exp_wr.push_back('{addr: 32'h202, data: 8'hEF, cyc: c0 + 1});
        exp_wr.push_back('{addr: 32'h203, data: 8'hBE, cyc: c0 + 2});
        exp_mem.push_back('{data: 32'd0, cyc: c0 + 3, chk_data: 1'b0});
        mem_req(1'b1, 32'h202, 4'b1100, 32'hBEEF_BEEF, 1'b1);

        // Store with no lanes enabled: completes without a RAM write
        c0 = cyc;
        exp_mem.push_back('{data: 32'd0, cyc: c0 + 1, chk_data: 1'b0});
        mem_req(1'b1, 32'h200, 4'b0000, 32'hFFFF_FFFF, 1'b1);

        // Misaligned load returns the aligned word
        c0 = cyc;
        exp_mem.push_back('{data: 32'hBEEF_5B5A, cyc: c0 + 6, chk_data: 1'b1});
        mem_req(1'b0, 32'h201, 4'hF, 32'd0, 1'b1);

        // Simultaneous MEM and IF requests: MEM first
        c0 = cyc;
        exp_mem.push_back('{data: 32'h4433_2211, cyc: c0 + 6,  chk_data: 1'b1});
        exp_if.push_back ('{data: 32'hEFBE_ADDE, cyc: c0 + 13, chk_data: 1'b1});
        fork
            mem_req(1'b0, 32'h100, 4'hF, 32'd0, 1'b1);
            if_req(32'h0, 1'b0);
        join

        // MEM request arriving during a fetch waits for it
        c0 = cyc;
        exp_if.push_back ('{data: 32'h6745_2301, cyc: c0 + 6,  chk_data: 1'b1});
        exp_mem.push_back('{data: 32'hBEEF_5B5A, cyc: c0 + 13, chk_data: 1'b1});
        fork
            if_req(32'h4, 1'b1);
            begin
                repeat (2) @(posedge clk);
                #1;
                mem_req(1'b0, 32'h201, 4'hF, 32'd0, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                for (int k = 2; k <= 12; k++) begin
                    @(negedge clk);
                    chk("arb_stallreq", {31'd0, stallreq_o}, 32'd1);
                end
            end
        join

        repeat (5) @(posedge clk);
        #1;
        chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
        chk("exp_if_drained",  32'(exp_if.size()),  32'd0);
        chk("exp_wr_drained",  32'(exp_wr.size()),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
